// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves EX-stage exceptions (Ov, AdEL, AdES) and
// forms store byte enables and lane-replicated store data for the data memory.
module ex_mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] DM_TOP   = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] ex_pc,
  input  logic        ex_bd,
  input  logic [4:0]  ex_exc,
  input  logic [31:0] alu_y,
  input  logic        alu_ov,
  input  logic        ov_trap,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_rt,
  input  logic [4:0]  ex_wa,
  input  logic        ex_we,
  output logic [31:0] mem_pc,
  output logic        mem_bd,
  output logic [4:0]  mem_exc,
  output logic [31:0] mem_y,
  output logic [3:0]  mem_memop,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_wa,
  output logic        mem_we
);

  localparam logic [3:0] MOP_NONE = 4'd0;
  localparam logic [3:0] MOP_LW   = 4'd1;
  localparam logic [3:0] MOP_LH   = 4'd2;
  localparam logic [3:0] MOP_LHU  = 4'd3;
  localparam logic [3:0] MOP_LB   = 4'd4;
  localparam logic [3:0] MOP_LBU  = 4'd5;
  localparam logic [3:0] MOP_SW   = 4'd6;
  localparam logic [3:0] MOP_SH   = 4'd7;
  localparam logic [3:0] MOP_SB   = 4'd8;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  function automatic logic in_range(input logic [31:0] a,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  logic        is_load_s;
  logic        is_store_s;
  logic        sub_word_s;
  logic        misaligned_s;
  logic        timer_s;
  logic        legal_s;
  logic        count_reg_s;
  logic        addr_fault_s;
  logic [3:0]  be_raw_s;

  logic [4:0]  exc_d;
  logic [3:0]  memop_d;
  logic [3:0]  byteen_d;
  logic [31:0] wdata_d;
  logic        we_d;

  logic [31:0] pc_q;
  logic        bd_q;
  logic [4:0]  exc_q;
  logic [31:0] y_q;
  logic [3:0]  memop_q;
  logic [3:0]  byteen_q;
  logic [31:0] wdata_q;
  logic [4:0]  wa_q;
  logic        we_q;

  // Decode memop into access class, width and alignment requirement.
  always_comb begin
    is_load_s    = 1'b0;
    is_store_s   = 1'b0;
    sub_word_s   = 1'b0;
    misaligned_s = 1'b0;
    case (ex_memop)
      MOP_LW: begin
        is_load_s    = 1'b1;
        misaligned_s = (alu_y[1:0] != 2'b00);
      end
      MOP_LH, MOP_LHU: begin
        is_load_s    = 1'b1;
        sub_word_s   = 1'b1;
        misaligned_s = alu_y[0];
      end
      MOP_LB, MOP_LBU: begin
        is_load_s  = 1'b1;
        sub_word_s = 1'b1;
      end
      MOP_SW: begin
        is_store_s   = 1'b1;
        misaligned_s = (alu_y[1:0] != 2'b00);
      end
      MOP_SH: begin
        is_store_s   = 1'b1;
        sub_word_s   = 1'b1;
        misaligned_s = alu_y[0];
      end
      MOP_SB: begin
        is_store_s = 1'b1;
        sub_word_s = 1'b1;
      end
      default: begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
      end
    endcase
  end

  // Address map checks; timers only accept full-word accesses.
  always_comb begin
    timer_s      = in_range(alu_y, 32'h0000_7F00, 32'h0000_7F0B) ||
                   in_range(alu_y, 32'h0000_7F10, 32'h0000_7F1B);
    legal_s      = (alu_y <= DM_TOP) || timer_s ||
                   in_range(alu_y, 32'h0000_7F20, 32'h0000_7F23);
    count_reg_s  = (alu_y == 32'h0000_7F08) || (alu_y == 32'h0000_7F18);
    addr_fault_s = alu_ov || misaligned_s || !legal_s || (timer_s && sub_word_s);
  end

  // Exception priority and the memory/register side effects it gates.
  always_comb begin
    if (ex_exc != EXC_NONE) begin
      exc_d = ex_exc;
    end else if (is_load_s && addr_fault_s) begin
      exc_d = EXC_ADEL;
    end else if (is_store_s && (addr_fault_s || count_reg_s)) begin
      exc_d = EXC_ADES;
    end else if (ov_trap && alu_ov) begin
      exc_d = EXC_OV;
    end else begin
      exc_d = EXC_NONE;
    end

    be_raw_s = 4'b0000;
    wdata_d  = ex_rt;
    case (ex_memop)
      MOP_SW: begin
        be_raw_s = 4'b1111;
        wdata_d  = ex_rt;
      end
      MOP_SH: begin
        be_raw_s = alu_y[1] ? 4'b1100 : 4'b0011;
        wdata_d  = {2{ex_rt[15:0]}};
      end
      MOP_SB: begin
        be_raw_s = 4'b0001 << alu_y[1:0];
        wdata_d  = {4{ex_rt[7:0]}};
      end
      default: begin
        be_raw_s = 4'b0000;
        wdata_d  = ex_rt;
      end
    endcase

    byteen_d = (exc_d == EXC_NONE) ? be_raw_s : 4'b0000;
    memop_d  = ((exc_d == EXC_NONE) && (is_load_s || is_store_s)) ? ex_memop : MOP_NONE;
    we_d     = ex_we && (exc_d == EXC_NONE);
  end

  // Stage register: flush keeps PC/bd for EPC, stall holds everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      bd_q     <= 1'b0;
      exc_q    <= 5'd0;
      y_q      <= 32'd0;
      memop_q  <= 4'd0;
      byteen_q <= 4'd0;
      wdata_q  <= 32'd0;
      wa_q     <= 5'd0;
      we_q     <= 1'b0;
    end else if (flush) begin
      pc_q     <= ex_pc;
      bd_q     <= ex_bd;
      exc_q    <= 5'd0;
      y_q      <= 32'd0;
      memop_q  <= 4'd0;
      byteen_q <= 4'd0;
      wdata_q  <= 32'd0;
      wa_q     <= 5'd0;
      we_q     <= 1'b0;
    end else if (!stall) begin
      pc_q     <= ex_pc;
      bd_q     <= ex_bd;
      exc_q    <= exc_d;
      y_q      <= alu_y;
      memop_q  <= memop_d;
      byteen_q <= byteen_d;
      wdata_q  <= wdata_d;
      wa_q     <= ex_wa;
      we_q     <= we_d;
    end
  end

  assign mem_pc     = pc_q;
  assign mem_bd     = bd_q;
  assign mem_exc    = exc_q;
  assign mem_y      = y_q;
  assign mem_memop  = memop_q;
  assign mem_byteen = byteen_q;
  assign mem_wdata  = wdata_q;
  assign mem_wa     = wa_q;
  assign mem_we     = we_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed cases plus randomized traffic
// checked against a behavioural model of the stage.
module tb_ex_mem_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DM_TOP   = 32'h0000_2FFF;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] ex_pc;
  logic        ex_bd;
  logic [4:0]  ex_exc;
  logic [31:0] alu_y;
  logic        alu_ov;
  logic        ov_trap;
  logic [3:0]  ex_memop;
  logic [31:0] ex_rt;
  logic [4:0]  ex_wa;
  logic        ex_we;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic [4:0]  mem_exc;
  logic [31:0] mem_y;
  logic [3:0]  mem_memop;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_wa;
  logic        mem_we;

  typedef struct packed {
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [31:0] y;
    logic [3:0]  memop;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        we;
  } exp_t;

  exp_t cur;
  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  ex_mem_stage #(.RESET_PC(RESET_PC), .DM_TOP(DM_TOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_pc(ex_pc), .ex_bd(ex_bd), .ex_exc(ex_exc), .alu_y(alu_y),
    .alu_ov(alu_ov), .ov_trap(ov_trap), .ex_memop(ex_memop), .ex_rt(ex_rt),
    .ex_wa(ex_wa), .ex_we(ex_we),
    .mem_pc(mem_pc), .mem_bd(mem_bd), .mem_exc(mem_exc), .mem_y(mem_y),
    .mem_memop(mem_memop), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .mem_wa(mem_wa), .mem_we(mem_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t reset_state();
    exp_t r;
    r    = '0;
    r.pc = RESET_PC;
    return r;
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a <= DM_TOP) || (a >= 32'h7F00 && a <= 32'h7F0B) ||
           (a >= 32'h7F10 && a <= 32'h7F1B) || (a >= 32'h7F20 && a <= 32'h7F23);
  endfunction

  function automatic bit is_timer(input logic [31:0] a);
    return (a >= 32'h7F00 && a <= 32'h7F1B);
  endfunction

  // Reference: access size in bytes drives alignment, lanes and replication.
  function automatic exp_t model(input exp_t c);
    exp_t        n;
    int          size;
    bit          ld;
    bit          st;
    bit          fault;
    logic [4:0]  e;
    n = '0;
    if (flush) begin
      n.pc = ex_pc;
      n.bd = ex_bd;
      return n;
    end
    if (stall) return c;
    ld    = (ex_memop >= 4'd1 && ex_memop <= 4'd5);
    st    = (ex_memop >= 4'd6 && ex_memop <= 4'd8);
    size  = (ex_memop == 4'd1 || ex_memop == 4'd6) ? 4 :
            (ex_memop == 4'd2 || ex_memop == 4'd3 || ex_memop == 4'd7) ? 2 : 1;
    fault = alu_ov || (alu_y % size != 0) || !legal(alu_y) || (size < 4 && is_timer(alu_y));
    if (ex_exc != 5'd0) e = ex_exc;
    else if (ld && fault) e = 5'd4;
    else if (st && (fault || alu_y == 32'h7F08 || alu_y == 32'h7F18)) e = 5'd5;
    else if (ov_trap && alu_ov) e = 5'd12;
    else e = 5'd0;
    n.pc    = ex_pc;
    n.bd    = ex_bd;
    n.exc   = e;
    n.y     = alu_y;
    n.wa    = ex_wa;
    n.we    = ex_we && (e == 5'd0);
    n.memop = (e != 5'd0 || !(ld || st)) ? 4'd0 : ex_memop;
    if (st && e == 5'd0)
      n.be = (size == 4) ? 4'hF : (size == 2) ? ((alu_y % 4 >= 2) ? 4'hC : 4'h3)
                                              : 4'(1 << (alu_y % 4));
    else
      n.be = 4'h0;
    if (!st)           n.wd = ex_rt;
    else if (size == 4) n.wd = ex_rt;
    else if (size == 2) n.wd = {16'h0000, ex_rt[15:0]} * 32'h0001_0001;
    else                n.wd = {24'h000000, ex_rt[7:0]} * 32'h0101_0101;
    return n;
  endfunction

  // Monitor: compare every output once per edge that has a pending expectation.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("mem_pc", mem_pc, e.pc);
      check("mem_bd", {31'd0, mem_bd}, {31'd0, e.bd});
      check("mem_exc", {27'd0, mem_exc}, {27'd0, e.exc});
      check("mem_y", mem_y, e.y);
      check("mem_memop", {28'd0, mem_memop}, {28'd0, e.memop});
      check("mem_byteen", {28'd0, mem_byteen}, {28'd0, e.be});
      check("mem_wdata", mem_wdata, e.wd);
      check("mem_wa", {27'd0, mem_wa}, {27'd0, e.wa});
      check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
    end
  end

  task automatic drive(input logic fl, input logic st, input logic [31:0] pc,
                       input logic [3:0] op, input logic [31:0] y, input logic [31:0] rt,
                       input logic ov, input logic trap, input logic [4:0] exc,
                       input logic we);
    flush    = fl;
    stall    = st;
    ex_pc    = pc;
    ex_memop = op;
    alu_y    = y;
    ex_rt    = rt;
    alu_ov   = ov;
    ov_trap  = trap;
    ex_exc   = exc;
    ex_we    = we;
    ex_bd    = 1'($urandom_range(0, 1));
    ex_wa    = 5'($urandom_range(0, 31));
    cur      = model(cur);
    q.push_back(cur);
    @(negedge clk);
  endtask

  task automatic op(input logic [3:0] o, input logic [31:0] y, input logic [31:0] rt);
    drive(1'b0, 1'b0, 32'h3000 + 32'($urandom_range(0, 255) * 4), o, y, rt,
          1'b0, 1'b0, 5'd0, 1'b1);
  endtask

  initial begin
    logic [31:0] y;
    int          sel;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; ex_pc = 32'd0; ex_bd = 1'b0;
    ex_exc = 5'd0; alu_y = 32'd0; alu_ov = 1'b0; ov_trap = 1'b0; ex_memop = 4'd0;
    ex_rt = 32'd0; ex_wa = 5'd0; ex_we = 1'b0;
    cur = reset_state();
    @(negedge clk);
    check("rst_pc", mem_pc, 32'h0000_3000);
    check("rst_byteen", {28'd0, mem_byteen}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    op(4'd6, 32'h10, 32'h1234_5678);
    check("sw_be", {28'd0, mem_byteen}, 32'hF);
    check("sw_wd", mem_wdata, 32'h1234_5678);
    check("sw_exc", {27'd0, mem_exc}, 32'd0);
    check("sw_y", mem_y, 32'h10);
    op(4'd8, 32'h13, 32'h0000_00AB);
    check("sb_be", {28'd0, mem_byteen}, 32'h8);
    check("sb_wd", mem_wdata, 32'hABAB_ABAB);
    op(4'd7, 32'h12, 32'h0000_BEEF);
    check("sh_be", {28'd0, mem_byteen}, 32'hC);
    check("sh_wd", mem_wdata, 32'hBEEF_BEEF);

    op(4'd1, 32'h6, 32'h0);
    check("lw_mis_exc", {27'd0, mem_exc}, 32'd4);
    check("lw_mis_we", {31'd0, mem_we}, 32'd0);
    check("lw_mis_op", {28'd0, mem_memop}, 32'd0);
    op(4'd7, 32'h7F04, 32'h1);
    check("sh_tmr_exc", {27'd0, mem_exc}, 32'd5);
    check("sh_tmr_be", {28'd0, mem_byteen}, 32'd0);
    op(4'd6, 32'h7F08, 32'h1);
    check("sw_cnt_exc", {27'd0, mem_exc}, 32'd5);
    op(4'd1, 32'h3000, 32'h0);
    check("lw_oob_exc", {27'd0, mem_exc}, 32'd4);
    op(4'd1, 32'h7F08, 32'h0);
    check("lw_cnt_exc", {27'd0, mem_exc}, 32'd0);

    drive(1'b0, 1'b0, 32'h3010, 4'd0, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 5'd0, 1'b1);
    check("ov_exc", {27'd0, mem_exc}, 32'd12);
    check("ov_we", {31'd0, mem_we}, 32'd0);
    drive(1'b0, 1'b0, 32'h3014, 4'd0, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 5'd0, 1'b1);
    check("addu_exc", {27'd0, mem_exc}, 32'd0);
    check("addu_we", {31'd0, mem_we}, 32'd1);
    drive(1'b0, 1'b0, 32'h3018, 4'd1, 32'h6, 32'h0, 1'b0, 1'b0, 5'd10, 1'b1);
    check("pass_exc", {27'd0, mem_exc}, 32'd10);

    op(4'd6, 32'h20, 32'h55);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, $urandom, 4'd8, $urandom, $urandom, 1'b0, 1'b0, 5'd0, 1'b1);
    check("stall_y", mem_y, 32'h20);
    check("stall_be", {28'd0, mem_byteen}, 32'hF);
    drive(1'b1, 1'b1, 32'h3040, 4'd6, 32'h24, 32'h77, 1'b0, 1'b0, 5'd0, 1'b1);
    check("flush_pc", mem_pc, 32'h3040);
    check("flush_be", {28'd0, mem_byteen}, 32'd0);
    check("flush_y", mem_y, 32'd0);

    op(4'd6, 32'h44, 32'h1111_2222);
    check("pre_rst_be", {28'd0, mem_byteen}, 32'hF);
    #2 reset = 1'b1;
    #1;
    check("async_rst_be", {28'd0, mem_byteen}, 32'd0);
    check("async_rst_pc", mem_pc, 32'h0000_3000);
    cur = reset_state();
    q.push_back(cur);
    @(negedge clk);
    reset = 1'b0;
    op(4'd6, 32'h48, 32'hCAFE_F00D);
    check("post_rst_be", {28'd0, mem_byteen}, 32'hF);
    check("post_rst_y", mem_y, 32'h48);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       y = 32'($urandom_range(0, 32'h3FFF));
        1:       y = DM_TOP - 32'd4 + 32'($urandom_range(0, 8));
        2:       y = 32'h7F00 + 32'($urandom_range(0, 39));
        3:       y = $urandom;
        default: y = 32'($urandom_range(0, 255));
      endcase
      drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0), $urandom,
            4'($urandom_range(0, 15)), y, $urandom,
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
            1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    check("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
